barrel_rotator_left_pipelined: RTL and testbench
================================================

// Module: barrel_rotator_left_pipelined
// PURPOSE
//   Left-rotation companion to the combinational right rotator, pipelined for high-frequency datapaths.
//   - Rotates data_in left by `rotation` positions (MSBs wrap into LSBs).
//   - One register stage per rotation bit; 1 beat/cycle throughput.
//   - Valid/ready handshake on both ends with full backpressure; sits between streaming producers and consumers.
// PARAMETERS
//   WIDTH       8            data width; power of two, >= 2 (else $error at elaboration)
//   WIDTH_LOG2  $clog2(WIDTH) rotation width and pipeline depth (localparam, not overridable)
// PORTS
//   clock         in   1           rising-edge clock
//   resetn        in   1           synchronous reset, active low
//   data_in       in   WIDTH       input word
//   rotation      in   WIDTH_LOG2  left-rotation amount, 0..WIDTH-1
//   input_valid   in   1           data_in/rotation valid
//   input_ready   out  1           block accepts beat this cycle
//   data_out      out  WIDTH       rotated word
//   output_valid  out  1           data_out valid
//   output_ready  in   1           consumer accepts beat this cycle
// BEHAVIOUR
//   - Reset: while resetn==0 at a rising edge, all stage valids <= 0 and all stage data/rotation <= 0.
//     Outputs after reset: output_valid=0, data_out=0, input_ready=1.
//     Reset mid-operation flushes every in-flight beat; none reappears after reset.
//   - Stages s=0..WIDTH_LOG2-1, each holding {valid_s, data_s, rot_s}.
//     Stage s applies rotate-left by 2^s if bit s of the beat's rotation is 1, else passes through.
//     rot_s carries the remaining bits forward.
//   - Stage s loads when ready_s = !valid_s || ready_{s+1}.
//     ready_{WIDTH_LOG2} = output_ready and input_ready = ready_0.
//     The ready chain is combinational and allows bubble-free flow.
//   - Transfers:
//     - Input transfer: input_valid && input_ready at a rising edge.
//     - Output transfer: output_valid && output_ready at a rising edge.
//   - A stage with valid_s=1 whose downstream is not ready holds its data/rot unchanged.
//     data_out stays stable while output_valid && !output_ready.
//   - A stage that loads takes valid_{s-1} (stage 0 takes input_valid).
//     When the upstream is invalid it loads valid=0; data may hold (do not care).
//   - Latency: a beat transferred in cycle c is presented with output_valid=1 in cycle c+WIDTH_LOG2,
//     given no stall.
//   - Throughput: 1 beat/cycle when output_ready is held 1. Capacity: WIDTH_LOG2 beats in flight.
//   - Full pipeline with output_ready=0: input_ready=0.
//     An output transfer and an input transfer in the same cycle are both legal; nothing is lost or duplicated.
//   - Rotation 0 returns data unchanged. Rotation amount is modulo WIDTH by construction.
//     Result is identical to {data_in,data_in} >> (WIDTH-rotation), taking the low WIDTH bits.
//   - No X propagation: the data path is driven from registers only.
//   - input_valid may drop without a transfer; holding stable is not required on the input side.
// TESTING (WIDTH=8)
//   1. Reset, then rotation 0..7 with data 8'b10011001 on consecutive cycles, output_ready=1.
//      -> outputs in order 99,33,66,CC,99,33,66,CC (hex), first at 3 cycles after its input transfer.
//   2. Send 8'hB4 with rotation 2, then 8'h01 with rotation 5.
//      -> 8'hD2 then 8'h20, on back-to-back cycles.
//   3. Hold output_ready=0 and stream beats.
//      -> exactly 3 accepted, then input_ready=0; data_out is stable while stalled.
//      Release output_ready -> all 3 emerge in order with no loss or duplication.
//   4. Random valid/ready toggling, 1000 beats, scoreboard model ((d<<r)|(d>>(8-r))) & 8'hFF.
//      -> all match, in order, zero drops.
//   5. Assert resetn=0 for 1 cycle with 3 beats in flight.
//      -> output_valid=0 and data_out=0 next cycle; no stale beat emerges afterwards.
//   6. Single beat followed by idle input.
//      -> output_valid pulses for exactly 1 cycle with output_ready=1, then stays 0.

Source files
------------

// File: rtl/barrel_rotator_left_pipelined_if.sv
// Streaming handshake bundle for the pipelined left rotator: input beat side and output beat side.
// The slave modport is the rotator's view; the master modport is the producer/consumer view.
interface barrel_rotator_left_pipelined_if #(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned WIDTH_LOG2 = $clog2(WIDTH);

  logic [WIDTH-1:0]      data_in;
  logic [WIDTH_LOG2-1:0] rotation;
  logic                  input_valid;
  logic                  input_ready;
  logic [WIDTH-1:0]      data_out;
  logic                  output_valid;
  logic                  output_ready;

  modport master (
    output data_in,
    output rotation,
    output input_valid,
    input  input_ready,
    input  data_out,
    input  output_valid,
    output output_ready
  );

  modport slave (
    input  data_in,
    input  rotation,
    input  input_valid,
    output input_ready,
    output data_out,
    output output_valid,
    input  output_ready
  );
endinterface

// File: rtl/barrel_rotator_left_pipelined.sv
// Pipelined left barrel rotator: stage s conditionally rotates by 2^s, one register per stage,
// with a combinational ready chain giving full backpressure and bubble-free 1 beat/cycle flow.
module barrel_rotator_left_pipelined #(
  parameter int unsigned WIDTH = 8
) (
  input logic                              clock,
  input logic                              resetn,
  barrel_rotator_left_pipelined_if.slave   bus_io
);
  localparam int unsigned WIDTH_LOG2 = $clog2(WIDTH);

  if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("barrel_rotator_left_pipelined: WIDTH must be a power of two >= 2");
  end

  logic [WIDTH_LOG2-1:0]                 valid_q, valid_d;
  logic [WIDTH_LOG2-1:0][WIDTH-1:0]      data_q, data_d;
  logic [WIDTH_LOG2-1:0][WIDTH_LOG2-1:0] rot_q, rot_d;

  // Per-stage upstream view: stage 0 sees the input port, stage s sees stage s-1.
  logic [WIDTH_LOG2-1:0]                 up_valid;
  logic [WIDTH_LOG2-1:0][WIDTH-1:0]      up_data;
  logic [WIDTH_LOG2-1:0][WIDTH_LOG2-1:0] up_rot;

  logic [WIDTH_LOG2:0]                   ready;
  logic [2*WIDTH-1:0]                    wide;

  always_comb begin
    up_valid    = '0;
    up_data     = '0;
    up_rot      = '0;
    up_valid[0] = bus_io.input_valid;
    up_data[0]  = bus_io.data_in;
    up_rot[0]   = bus_io.rotation;
    for (int s = 1; s < int'(WIDTH_LOG2); s++) begin
      up_valid[s] = valid_q[s-1];
      up_data[s]  = data_q[s-1];
      up_rot[s]   = rot_q[s-1];
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    rot_d   = rot_q;
    ready   = '0;
    wide    = '0;

    // Walk from the output back so each stage sees its downstream readiness.
    ready[WIDTH_LOG2] = bus_io.output_ready;
    for (int s = int'(WIDTH_LOG2) - 1; s >= 0; s--) begin
      ready[s] = !valid_q[s] || ready[s+1];
    end

    for (int s = 0; s < int'(WIDTH_LOG2); s++) begin
      if (ready[s]) begin
        valid_d[s] = up_valid[s];
        // Data only moves with a real beat; an empty stage keeps its old contents.
        if (up_valid[s]) begin
          wide      = {up_data[s], up_data[s]} << (1 << s);
          data_d[s] = up_rot[s][s] ? wide[2*WIDTH-1 -: WIDTH] : up_data[s];
          rot_d[s]  = up_rot[s];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      valid_q <= '0;
      data_q  <= '0;
      rot_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      rot_q   <= rot_d;
    end
  end

  assign bus_io.input_ready  = ready[0];
  assign bus_io.data_out     = data_q[WIDTH_LOG2-1];
  assign bus_io.output_valid = valid_q[WIDTH_LOG2-1];
endmodule

// File: tb/tb_barrel_rotator_left_pipelined.sv
// Bench for the pipelined left rotator: directed vector table, stall/reset/pulse sequences,
// and randomized valid/ready traffic scored against an arithmetic rotate model.
module tb_barrel_rotator_left_pipelined;
  localparam int unsigned W = 8;

  typedef struct {
    logic [7:0] data;
    logic [2:0] rot;
    logic [7:0] exp;
  } vec_t;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  barrel_rotator_left_pipelined_if #(.WIDTH(W)) bus ();

  barrel_rotator_left_pipelined #(.WIDTH(W)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus_io (bus)
  );

  int         nvec    = 0;
  int         nmis    = 0;
  int         cyc     = 0;
  int         out_cnt = 0;
  bit         done    = 1'b0;
  logic [7:0] exp_q[$];
  int         in_cyc_q[$];
  logic [7:0] obs_q[$];
  int         lat_q[$];
  logic [7:0] mon_e;
  int         mon_c;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [7:0] rotl_ref(input logic [7:0] d, input int r);
    int x;
    x = int'(d);
    return 8'(((x << r) | (x >> (8 - r))) & 255);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Transfers are observed mid-cycle, where handshake signals are settled for the next edge.
  always @(negedge clock) begin
    if (resetn) begin
      if (bus.input_valid && bus.input_ready) begin
        exp_q.push_back(rotl_ref(bus.data_in, int'(bus.rotation)));
        in_cyc_q.push_back(cyc);
      end
      if (bus.output_valid && bus.output_ready) begin
        out_cnt++;
        if (exp_q.size() == 0) begin
          nvec++;
          nmis++;
          $display("FAIL unexpected_beat: got data_out %0h, want no beat", bus.data_out);
        end else begin
          mon_e = exp_q.pop_front();
          mon_c = in_cyc_q.pop_front();
          check("scoreboard", 32'(bus.data_out), 32'(mon_e));
          obs_q.push_back(bus.data_out);
          lat_q.push_back(cyc - mon_c);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic [2:0] r);
    int n;
    n = 0;
    bus.data_in     = d;
    bus.rotation    = r;
    bus.input_valid = 1'b1;
    @(negedge clock);
    while (!bus.input_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) check("send_timeout", 32'(bus.input_ready), 32'd1);
    @(posedge clock);
    #1;
    bus.input_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clock);
      #1;
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tbl[12];
    logic [7:0] t1_exp[8];
    logic [7:0] held;
    bit         have;
    int         acc, start, pulses;

    t1_exp = '{8'h99, 8'h33, 8'h66, 8'hCC, 8'h99, 8'h33, 8'h66, 8'hCC};
    for (int i = 0; i < 8; i++) tbl[i] = '{8'h99, 3'(i), t1_exp[i]};
    tbl[8]  = '{8'hB4, 3'd2, 8'hD2};
    tbl[9]  = '{8'h01, 3'd5, 8'h20};
    tbl[10] = '{8'hA5, 3'd1, 8'h4B};
    tbl[11] = '{8'h0F, 3'd7, 8'h87};

    bus.input_valid  = 1'b0;
    bus.data_in      = '0;
    bus.rotation     = '0;
    bus.output_ready = 1'b1;

    // Reset state
    resetn = 1'b0;
    idle(3);
    check("reset_out_valid", 32'(bus.output_valid), 32'd0);
    check("reset_data_out", 32'(bus.data_out), 32'd0);
    check("reset_in_ready", 32'(bus.input_ready), 32'd1);
    resetn = 1'b1;
    idle(1);

    // Table vectors, streamed back-to-back with the consumer always ready
    obs_q.delete();
    lat_q.delete();
    foreach (tbl[i]) send(tbl[i].data, tbl[i].rot);
    drain();
    check("tbl_count", 32'(obs_q.size()), 32'd12);
    for (int i = 0; i < 12 && i < obs_q.size(); i++) begin
      check("tbl_data", 32'(obs_q[i]), 32'(tbl[i].exp));
      check("tbl_latency", 32'(lat_q[i]), 32'd3);
    end

    // Stall: consumer blocked, pipeline fills to capacity and output holds
    bus.output_ready = 1'b0;
    acc  = 0;
    have = 1'b0;
    held = '0;
    for (int k = 0; k < 8; k++) begin
      bus.input_valid = 1'b1;
      bus.data_in     = 8'(8'h10 + k);
      bus.rotation    = 3'(k + 1);
      @(negedge clock);
      if (bus.input_ready) acc++;
      if (bus.output_valid) begin
        if (!have) begin
          held = bus.data_out;
          have = 1'b1;
        end else begin
          check("stall_stable", 32'(bus.data_out), 32'(held));
        end
      end
      @(posedge clock);
      #1;
    end
    bus.input_valid = 1'b0;
    check("stall_accepted", 32'(acc), 32'd3);
    check("stall_in_ready", 32'(bus.input_ready), 32'd0);
    check("stall_out_valid", 32'(bus.output_valid), 32'd1);
    obs_q.delete();
    bus.output_ready = 1'b1;
    drain();
    check("stall_drained", 32'(obs_q.size()), 32'd3);

    // Random traffic with independent producer gaps and consumer backpressure
    start = out_cnt;
    done  = 1'b0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
          send(8'($urandom), 3'($urandom));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clock);
          #1;
          bus.output_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    bus.output_ready = 1'b1;
    drain();
    check("random_count", 32'(out_cnt - start), 32'd1000);

    // Reset with three beats in flight flushes them all
    bus.output_ready = 1'b0;
    send(8'hC3, 3'd1);
    send(8'h3C, 3'd2);
    send(8'hF0, 3'd3);
    resetn = 1'b0;
    idle(1);
    resetn = 1'b1;
    exp_q.delete();
    in_cyc_q.delete();
    check("flush_out_valid", 32'(bus.output_valid), 32'd0);
    check("flush_data_out", 32'(bus.data_out), 32'd0);
    check("flush_in_ready", 32'(bus.input_ready), 32'd1);
    start = out_cnt;
    bus.output_ready = 1'b1;
    idle(10);
    check("flush_no_stale", 32'(out_cnt - start), 32'd0);

    // Single beat then idle: exactly one valid cycle
    start  = out_cnt;
    pulses = 0;
    send(8'h5A, 3'd4);
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (bus.output_valid) pulses++;
      @(posedge clock);
      #1;
    end
    check("pulse_cycles", 32'(pulses), 32'd1);
    check("pulse_beats", 32'(out_cnt - start), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
